// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile: FSM state encoding,
// default operand buffer widths and the default drain length.
package systolic_pkg;

    localparam int SIZE_DEF       = 16;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int K_WIDTH_DEF    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Read latency 1 + skew SIZE-1 + array propagation SIZE.
    function automatic int drain_cycles(input int size);
        return 2 * size;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Sequences one K-reduction pass of a systolic tile: linear operand reads,
// data_setup strobes one cycle behind each read, drain wait, done pulse.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int SIZE         = SIZE_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int K_WIDTH      = K_WIDTH_DEF,
    parameter int DRAIN_CYCLES = drain_cycles(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [K_WIDTH-1:0]    k_len_i,
    input  logic [ADDR_WIDTH-1:0] a_base_i,
    input  logic [ADDR_WIDTH-1:0] b_base_i,
    input  logic                  stall_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] a_rd_addr_o,
    output logic [ADDR_WIDTH-1:0] b_rd_addr_o,
    output logic                  input_valid_o,
    output logic                  is_init_data_o,
    output logic                  calc_done_o,
    output logic                  busy_o,
    output logic                  done_o,
    output state_t                dbg_state_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t                r_state, w_state_nxt;
    logic [K_WIDTH-1:0]    r_k_len, w_k_len_nxt;
    logic [ADDR_WIDTH-1:0] r_a_base, w_a_base_nxt;
    logic [ADDR_WIDTH-1:0] r_b_base, w_b_base_nxt;
    logic [K_WIDTH-1:0]    r_beat, w_beat_nxt;
    logic [DW-1:0]         r_drain, w_drain_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0] r_a_addr, w_a_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_b_addr, w_b_addr_nxt;
    logic                  r_first, w_first_nxt;
    logic                  r_last, w_last_nxt;
    logic                  r_valid, r_init, r_calc, r_busy, r_done;
    logic [ADDR_WIDTH-1:0] w_beat_addr;

    assign w_beat_addr = ADDR_WIDTH'(r_beat);

    // r_beat counts beats already issued; the first beat issues on the start edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_k_len_nxt  = r_k_len;
        w_a_base_nxt = r_a_base;
        w_b_base_nxt = r_b_base;
        w_beat_nxt   = r_beat;
        w_drain_nxt  = r_drain;
        w_rd_en_nxt  = 1'b0;
        w_a_addr_nxt = r_a_addr;
        w_b_addr_nxt = r_b_addr;
        w_first_nxt  = 1'b0;
        w_last_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_k_len_nxt  = k_len_i;
                    w_a_base_nxt = a_base_i;
                    w_b_base_nxt = b_base_i;
                    w_beat_nxt   = '0;
                    if (k_len_i != '0) begin
                        w_state_nxt  = LOAD;
                        w_rd_en_nxt  = 1'b1;
                        w_a_addr_nxt = a_base_i;
                        w_b_addr_nxt = b_base_i;
                        w_first_nxt  = 1'b1;
                        w_last_nxt   = (k_len_i == K_WIDTH'(1));
                        w_beat_nxt   = K_WIDTH'(1);
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                w_a_addr_nxt = r_a_base + w_beat_addr;
                w_b_addr_nxt = r_b_base + w_beat_addr;
                if (r_beat == r_k_len) begin
                    w_state_nxt  = DRAIN;
                    w_drain_nxt  = DW'(DRAIN_CYCLES - 1);
                    w_a_addr_nxt = r_a_addr;
                    w_b_addr_nxt = r_b_addr;
                end else if (!stall_i) begin
                    w_rd_en_nxt = 1'b1;
                    w_first_nxt = (r_beat == '0);
                    w_last_nxt  = (r_beat == r_k_len - K_WIDTH'(1));
                    w_beat_nxt  = r_beat + K_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (r_drain == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_nxt = r_drain - DW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k_len  <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_beat   <= '0;
            r_drain  <= '0;
            r_rd_en  <= 1'b0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_init   <= 1'b0;
            r_calc   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_k_len  <= w_k_len_nxt;
            r_a_base <= w_a_base_nxt;
            r_b_base <= w_b_base_nxt;
            r_beat   <= w_beat_nxt;
            r_drain  <= w_drain_nxt;
            r_rd_en  <= w_rd_en_nxt;
            r_a_addr <= w_a_addr_nxt;
            r_b_addr <= w_b_addr_nxt;
            r_first  <= w_first_nxt;
            r_last   <= w_last_nxt;
            // Strobes trail the read by the buffer's one-cycle latency.
            r_valid  <= r_rd_en;
            r_init   <= r_first;
            r_calc   <= r_last;
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (w_state_nxt == DONE);
        end
    end

    assign rd_en_o        = r_rd_en;
    assign a_rd_addr_o    = r_a_addr;
    assign b_rd_addr_o    = r_b_addr;
    assign input_valid_o  = r_valid;
    assign is_init_data_o = r_init;
    assign calc_done_o    = r_calc;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: table of directed passes, randomized passes
// against a timeline model, plus reset-at-startup and reset-mid-LOAD sequences.
module tb_systolic_feed_ctrl;
    import systolic_pkg::*;

    localparam int SIZE  = 4;
    localparam int AW    = 12;
    localparam int KW    = 16;
    localparam int DRAIN = 8;
    localparam int MAXC  = 160;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [KW-1:0] k_len_i;
    logic [AW-1:0] a_base_i;
    logic [AW-1:0] b_base_i;
    logic          stall_i;
    logic          rd_en_o;
    logic [AW-1:0] a_rd_addr_o;
    logic [AW-1:0] b_rd_addr_o;
    logic          input_valid_o;
    logic          is_init_data_o;
    logic          calc_done_o;
    logic          busy_o;
    logic          done_o;
    state_t        dbg_state_o;

    systolic_feed_ctrl #(
        .SIZE(SIZE), .ADDR_WIDTH(AW), .K_WIDTH(KW), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .k_len_i(k_len_i),
        .a_base_i(a_base_i), .b_base_i(b_base_i), .stall_i(stall_i),
        .rd_en_o(rd_en_o), .a_rd_addr_o(a_rd_addr_o), .b_rd_addr_o(b_rd_addr_o),
        .input_valid_o(input_valid_o), .is_init_data_o(is_init_data_o),
        .calc_done_o(calc_done_o), .busy_o(busy_o), .done_o(done_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected per-cycle trace, cycle 0 being the cycle start_i is driven.
    logic          e_rd[MAXC], e_valid[MAXC], e_init[MAXC], e_calc[MAXC];
    logic          e_busy[MAXC], e_done[MAXC], e_achk[MAXC];
    logic [AW-1:0] e_a[MAXC], e_b[MAXC];

    typedef struct {
        int              k;
        logic [AW-1:0]   a;
        logic [AW-1:0]   b;
        logic [MAXC-1:0] st;
        int              restart;
        int              exp_done;
        int              exp_rd;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // Beat 0 issues the cycle after start; each later beat issues at the next
    // cycle whose preceding cycle had stall_i low. Stalled slots show the
    // pending beat's address.
    task automatic build_model(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [MAXC-1:0] st, output int done_cyc);
        int t;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_valid[c] = 0; e_init[c] = 0; e_calc[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_achk[c] = 0; e_a[c] = '0; e_b[c] = '0;
        end
        if (k == 0) begin
            done_cyc = 1;
        end else begin
            t = 1;
            for (int i = 0; i < k; i++) begin
                if (i > 0) begin
                    t++;
                    while (st[t-1]) begin
                        e_achk[t] = 1; e_a[t] = a + AW'(i); e_b[t] = b + AW'(i);
                        t++;
                    end
                end
                e_rd[t] = 1; e_achk[t] = 1; e_a[t] = a + AW'(i); e_b[t] = b + AW'(i);
                e_valid[t+1] = 1;
                e_init[t+1]  = (i == 0);
                e_calc[t+1]  = (i == k - 1);
            end
            done_cyc = t + 1 + DRAIN;
        end
        for (int c = 1; c <= done_cyc; c++) e_busy[c] = 1;
        e_done[done_cyc] = 1;
    endtask

    task automatic run_pass(input int k, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [MAXC-1:0] st, input int restart_cyc,
                            output int done_seen, output int rd_cnt);
        int done_cyc;
        build_model(k, a, b, st, done_cyc);
        done_seen = -1;
        rd_cnt    = 0;
        for (int c = 0; c <= done_cyc + 2; c++) begin
            @(negedge clk);
            check("rd_en", c, 32'(rd_en_o), 32'(e_rd[c]));
            check("input_valid", c, 32'(input_valid_o), 32'(e_valid[c]));
            check("is_init_data", c, 32'(is_init_data_o), 32'(e_init[c]));
            check("calc_done", c, 32'(calc_done_o), 32'(e_calc[c]));
            check("busy", c, 32'(busy_o), 32'(e_busy[c]));
            check("done", c, 32'(done_o), 32'(e_done[c]));
            if (e_achk[c]) begin
                check("a_rd_addr", c, 32'(a_rd_addr_o), 32'(e_a[c]));
                check("b_rd_addr", c, 32'(b_rd_addr_o), 32'(e_b[c]));
            end
            if (done_o && done_seen < 0) done_seen = c;
            if (rd_en_o) rd_cnt++;
            start_i = (c == 0) || (restart_cyc != 0 && c == restart_cyc);
            if (c == 0) begin
                k_len_i = KW'(k); a_base_i = a; b_base_i = b;
            end else if (start_i) begin
                k_len_i = KW'(7); a_base_i = ~a; b_base_i = ~b;
            end
            stall_i = st[c];
        end
        start_i = 0;
        stall_i = 0;
    endtask

    initial begin
        int done_seen;
        int rd_cnt;
        logic [MAXC-1:0] st;

        rst = 1; start_i = 0; k_len_i = '0; a_base_i = '0; b_base_i = '0; stall_i = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", 0, 32'(busy_o), 0);
        check("reset_rd_en", 0, 32'(rd_en_o), 0);
        check("reset_a_addr", 0, 32'(a_rd_addr_o), 0);
        check("reset_b_addr", 0, 32'(b_rd_addr_o), 0);
        check("reset_strobes", 0, 32'({input_valid_o, is_init_data_o, calc_done_o, done_o}), 0);
        rst = 0;

        // Stall is driven in the cycle before each suppressed issue slot.
        tbl[0] = '{k: 4, a: 12'h010, b: 12'h200, st: '0,  restart: 0,  exp_done: 13, exp_rd: 4};
        tbl[1] = '{k: 4, a: 12'h010, b: 12'h200, st: 'h6, restart: 0,  exp_done: 15, exp_rd: 4};
        tbl[2] = '{k: 1, a: 12'h010, b: 12'h200, st: '0,  restart: 0,  exp_done: 10, exp_rd: 1};
        tbl[3] = '{k: 0, a: 12'h010, b: 12'h200, st: '0,  restart: 0,  exp_done: 1,  exp_rd: 0};
        tbl[4] = '{k: 0, a: 12'h010, b: 12'h200, st: '0,  restart: 1,  exp_done: 1,  exp_rd: 0};
        tbl[5] = '{k: 4, a: 12'hFFE, b: 12'h7FF, st: '0,  restart: 0,  exp_done: 13, exp_rd: 4};
        tbl[6] = '{k: 4, a: 12'h010, b: 12'h200, st: '0,  restart: 3,  exp_done: 13, exp_rd: 4};
        tbl[7] = '{k: 4, a: 12'h010, b: 12'h200, st: '0,  restart: 13, exp_done: 13, exp_rd: 4};

        foreach (tbl[i]) begin
            run_pass(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].st, tbl[i].restart, done_seen, rd_cnt);
            check("tbl_done_cycle", i, 32'(done_seen), 32'(tbl[i].exp_done));
            check("tbl_rd_count", i, 32'(rd_cnt), 32'(tbl[i].exp_rd));
        end

        // Reset during LOAD: everything clears on the next edge, no done pulse.
        @(negedge clk);
        start_i = 1; k_len_i = KW'(4); a_base_i = 12'h010; b_base_i = 12'h200;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_i = 0;
            check("rst_seq_done", c, 32'(done_o), 0);
            if (c == 3) rst = 1;
            if (c == 4) begin
                check("rst_seq_busy", c, 32'(busy_o), 0);
                check("rst_seq_rd_en", c, 32'(rd_en_o), 0);
                check("rst_seq_addr", c, 32'({a_rd_addr_o, b_rd_addr_o}), 0);
                check("rst_seq_strobes", c, 32'({input_valid_o, is_init_data_o, calc_done_o}), 0);
                rst = 0;
            end
        end
        run_pass(4, 12'h010, 12'h200, '0, 0, done_seen, rd_cnt);
        check("post_rst_done_cycle", 0, 32'(done_seen), 13);

        for (int n = 0; n < 20; n++) begin
            st = '0;
            for (int c = 1; c <= 60; c++) st[c] = ($urandom_range(0, 3) == 0);
            run_pass($urandom_range(0, 20), AW'($urandom), AW'($urandom), st, 0, done_seen, rd_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
